// File: rtl/carregador_programa.sv
// Program loader: parses a byte stream (word count, LSB-first words, XOR checksum)
// into instruction-memory writes and holds the CPU until a good image is loaded.
module carregador_programa #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

    state_t          state;
    logic [15:0]     count;
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_idx;
    logic [31:0]     word;
    logic [7:0]      chk;
    logic            accept;
    logic [15:0]     hdr_n;
    logic [16:0]     next_idx;

    // All status outputs are decoded from state only, so reset forces them at once.
    assign byte_ready = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CHK);
    assign mem_we     = (state == WRITE);
    assign busy       = (state == HDR0) || (state == HDR1) || (state == DATA) ||
                        (state == WRITE) || (state == CHK);
    assign done       = (state == DONE);
    assign error      = (state == ERR);
    assign cpu_hold   = (state != DONE);

    assign accept   = byte_valid && byte_ready;
    assign hdr_n    = {byte_in, count[7:0]};
    assign next_idx = 17'(word_idx) + 17'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word     <= '0;
            chk      <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        chk      <= '0;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        count[7:0] <= byte_in;
                        chk        <= chk ^ byte_in;
                        state      <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        count <= hdr_n;
                        chk   <= chk ^ byte_in;
                        if (hdr_n == 16'd0)
                            state <= CHK;
                        else if ({1'b0, hdr_n} > MAX_N)
                            state <= ERR;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word[{byte_idx, 3'b000} +: 8] <= byte_in;
                        chk      <= chk ^ byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        // Latch address and the completed word so they are stable throughout WRITE.
                        if (byte_idx == 2'd3) begin
                            mem_addr <= word_idx[ADDR_W-1:0];
                            mem_data <= {byte_in, word[23:0]};
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    word_idx <= next_idx[ADDR_W:0];
                    if (next_idx == {1'b0, count})
                        state <= CHK;
                    else
                        state <= DATA;
                end
                CHK: begin
                    if (accept)
                        state <= (byte_in == chk) ? DONE : ERR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: cycle table for the basic load plus
// hand-written sequences for checksum error, empty image, oversize header, stalls and reset.
module tb_carregador_programa;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, mem_we, cpu_hold, busy, done, error;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;

    carregador_programa #(.ADDR_W(10)) dut (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int nvec = 0;
    int nfail = 0;
    int ready_in_write = 0;
    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    logic [9:0]  exp_a[$];
    logic [31:0] exp_d[$];

    // Flag order: {byte_ready, mem_we, busy, done, error, cpu_hold}
    localparam logic [5:0] F_IDLE = 6'b000001;
    localparam logic [5:0] F_BUSY = 6'b101001;
    localparam logic [5:0] F_WR   = 6'b011001;
    localparam logic [5:0] F_DONE = 6'b000100;
    localparam logic [5:0] F_ERR  = 6'b000011;

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  b;
        logic [47:0] exp;
    } vec_t;

    vec_t tab[16];

    always @(negedge clock) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            if (byte_ready) ready_in_write++;
        end
    end

    function automatic logic [47:0] outs();
        return {byte_ready, mem_we, busy, done, error, cpu_hold, mem_addr, mem_data};
    endfunction

    function automatic vec_t mk(input logic st, input logic vl, input logic [7:0] b,
                                input logic [5:0] fl, input logic [9:0] a, input logic [31:0] d);
        vec_t v;
        v.st = st; v.vl = vl; v.b = b; v.exp = {fl, a, d};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_writes();
        wa.delete(); wd.delete(); exp_a.delete(); exp_d.delete();
    endtask

    task automatic check_writes(input string name);
        int bad = 0;
        chk({name, "_count"}, 64'(wa.size()), 64'(exp_a.size()));
        for (int i = 0; i < wa.size() && i < exp_a.size(); i++)
            if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) bad++;
        chk({name, "_content"}, 64'(bad), 64'd0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1; byte_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard = 0;
        bit acc = 1'b0;
        while (!acc) begin
            @(negedge clock);
            byte_in = b;
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = byte_valid && byte_ready;
            @(posedge clock);
            guard++;
            if (!acc && guard > 200) begin
                chk("byte_accept_timeout", 64'd0, 64'd1);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit rnd);
        foreach (s[i]) send_byte(s[i], rnd);
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic expect_basic_writes();
        exp_a.push_back(10'd0); exp_d.push_back(32'h0000_0013);
        exp_a.push_back(10'd1); exp_d.push_back(32'h0000_0137);
    endtask

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad_stream[$];
        logic [7:0] big[$];
        logic [7:0] x;

        #900000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad_stream[$];
        logic [7:0] big[$];
        logic [7:0] cs;
        logic [31:0] w;

        good       = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h01, 8'h00, 8'h00, 8'h27};
        bad_stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h01, 8'h00, 8'h00, 8'h00};

        tab[0]  = mk(1, 0, 8'h00, F_BUSY, 10'd0, 32'h0);
        tab[1]  = mk(0, 1, 8'h02, F_BUSY, 10'd0, 32'h0);
        tab[2]  = mk(0, 1, 8'h00, F_BUSY, 10'd0, 32'h0);
        tab[3]  = mk(0, 1, 8'h13, F_BUSY, 10'd0, 32'h0);
        tab[4]  = mk(1, 1, 8'h00, F_BUSY, 10'd0, 32'h0);
        tab[5]  = mk(0, 0, 8'h55, F_BUSY, 10'd0, 32'h0);
        tab[6]  = mk(0, 1, 8'h00, F_BUSY, 10'd0, 32'h0);
        tab[7]  = mk(0, 1, 8'h00, F_WR,   10'd0, 32'h0000_0013);
        tab[8]  = mk(0, 1, 8'hAA, F_BUSY, 10'd0, 32'h0000_0013);
        tab[9]  = mk(0, 1, 8'h37, F_BUSY, 10'd0, 32'h0000_0013);
        tab[10] = mk(0, 1, 8'h01, F_BUSY, 10'd0, 32'h0000_0013);
        tab[11] = mk(0, 1, 8'h00, F_BUSY, 10'd0, 32'h0000_0013);
        tab[12] = mk(0, 1, 8'h00, F_WR,   10'd1, 32'h0000_0137);
        tab[13] = mk(0, 1, 8'h27, F_BUSY, 10'd1, 32'h0000_0137);
        tab[14] = mk(0, 1, 8'h27, F_DONE, 10'd1, 32'h0000_0137);
        tab[15] = mk(0, 0, 8'h00, F_DONE, 10'd1, 32'h0000_0137);

        // Reset state
        #3 reset = 1'b0;
        #1 chk("reset_outputs", 64'(outs()), 64'({F_IDLE, 10'd0, 32'd0}));
        @(negedge clock);
        reset = 1'b1;

        // Cycle table: two-word load with stall, ignored start and a byte offered during WRITE
        clear_writes();
        foreach (tab[i]) begin
            @(negedge clock);
            start = tab[i].st; byte_valid = tab[i].vl; byte_in = tab[i].b;
            @(posedge clock);
            #1 chk($sformatf("table_%0d", i), 64'(outs()), 64'(tab[i].exp));
        end
        expect_basic_writes();
        check_writes("table_writes");

        // Bad checksum, then a good reload
        clear_writes();
        pulse_start();
        send_stream(bad_stream, 1'b0);
        chk("badsum_flags", 64'({done, error, cpu_hold}), 64'(3'b011));
        expect_basic_writes();
        check_writes("badsum_writes");
        clear_writes();
        pulse_start();
        send_stream(good, 1'b0);
        chk("reload_flags", 64'({done, error, cpu_hold}), 64'(3'b100));
        expect_basic_writes();
        check_writes("reload_writes");

        // Empty image
        clear_writes();
        pulse_start();
        send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
        chk("empty_flags", 64'({done, error, cpu_hold}), 64'(3'b100));
        check_writes("empty_writes");

        // Oversize header N=1025 fails on header acceptance
        clear_writes();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        #1 chk("oversize_flags", 64'({busy, done, error, cpu_hold}), 64'(4'b0011));
        @(negedge clock);
        byte_valid = 1'b0;
        check_writes("oversize_writes");

        // Randomly stalled stream
        clear_writes();
        pulse_start();
        send_stream(good, 1'b1);
        chk("stall_flags", 64'({done, error, cpu_hold}), 64'(3'b100));
        expect_basic_writes();
        check_writes("stall_writes");

        // Async reset after the first word, then reload from address 0
        clear_writes();
        pulse_start();
        send_stream('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37}, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 chk("midload_reset_outputs", 64'(outs()), 64'({F_IDLE, 10'd0, 32'd0}));
        exp_a.push_back(10'd0); exp_d.push_back(32'h0000_0013);
        check_writes("midload_writes");
        @(negedge clock);
        reset = 1'b1;
        clear_writes();
        pulse_start();
        send_stream(good, 1'b0);
        chk("after_reset_flags", 64'({done, error, cpu_hold}), 64'(3'b100));
        expect_basic_writes();
        check_writes("after_reset_writes");

        // Full-depth image: N=1024 fills addresses 0..1023 without wrap
        clear_writes();
        big = '{8'h00, 8'h04};
        cs = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i) * 32'h0001_0003 ^ 32'hA500_0000;
            exp_a.push_back(10'(i)); exp_d.push_back(w);
            for (int k = 0; k < 4; k++) begin
                big.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        big.push_back(cs);
        pulse_start();
        send_stream(big, 1'b0);
        chk("full_flags", 64'({done, error, cpu_hold}), 64'(3'b100));
        check_writes("full_writes");

        chk("ready_during_write", 64'(ready_in_write), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
